alu_result_fifo: RTL

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_result_fifo.sv | 92 +++++++++
 1 files changed

// File: rtl/alu_result_fifo.sv
// Small FIFO that buffers ALU results {op, o, cout, zero} between the ALU and a consumer.
// Also tracks a sticky carry flag across accepted results until cleared.
module alu_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic [15:0]              o,
    input  logic                     cout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_op,
    output logic [15:0]              out_data,
    output logic                     out_cout,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clr_sticky,
    output logic                     sticky_carry
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [19:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          r_sticky;

    logic          w_push;
    logic          w_pop;
    logic          w_zero;
    logic [19:0]   w_headEntry;

    assign in_ready     = (r_count < FULL_COUNT);
    assign out_valid    = (r_count != '0);
    assign w_push       = in_valid && in_ready;
    assign w_pop        = out_valid && out_ready;
    assign w_zero       = (o == 16'h0000);
    assign count        = r_count;
    assign sticky_carry = r_sticky;

    // Storage is never reset; only entries covered by count are ever observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {op, o, cout, w_zero};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A carry arriving in the same cycle as a clear must not be lost, so set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky <= 1'b0;
        end else if (w_push && cout) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    always_comb begin
        w_headEntry = out_valid ? r_mem[r_rdPtr] : 20'h00000;
        out_op      = w_headEntry[19:18];
        out_data    = w_headEntry[17:2];
        out_cout    = w_headEntry[1];
        out_zero    = w_headEntry[0];
    end

endmodule
